inst_buffer: RTL and testbench
==============================

Name: inst_buffer

Overview:
N-wide circular FIFO between fetch/decode and dispatch.
- Absorbs up to N fetched instructions per cycle.
- Presents the oldest up to N to dispatch and retires however many dispatch reports as taken.
- Is emptied on branch-stack restore.
- Supplies dispatch's instruction-valid count and holds fetch back via a free-spots count.

Parameters:
N, 3, superscalar width (lanes per cycle)
DEPTH, 16, buffer entries; must be >= N; need not be a power of two
CNT_BITS, $clog2(N+1), width of per-cycle counts
PTR_BITS, $clog2(DEPTH), head/tail pointer width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
fetch_packets  input  N x FETCH_PACKET  lane 0 is oldest; valid lanes contiguous from lane 0
fetch_valid  input  CNT_BITS  number of valid fetch lanes
ib_spots  output  CNT_BITS  min(N, DEPTH - count); fetch must not exceed it
ib_packets  output  N x FETCH_PACKET  entries head..head+N-1, lane 0 oldest
inst_buffer_instructions_valid  output  CNT_BITS  min(N, count)
num_dispatched  input  CNT_BITS  lanes consumed by dispatch this cycle
flush  input  1  branch-stack restore_valid; empties buffer
ib_count  output  $clog2(DEPTH+1)  current occupancy (for perf/debug)

Behaviour:
- State: head, tail (PTR_BITS), count, storage[DEPTH].
- All outputs are combinational from registered state only, except under IB_BYPASS_EN.
- Reset (async):
  - head = tail = count = 0.
  - ib_spots = min(N, DEPTH); inst_buffer_instructions_valid = 0; ib_packets = 0.
  - Storage contents are don't-care.
- Enqueue:
  - accepted = min(fetch_valid, ib_spots), where ib_spots is computed from pre-dequeue count.
  - Same-cycle dequeue space is not reused.
  - Lane k is written to storage[(tail + k) mod DEPTH]; tail advances by accepted, mod DEPTH.
  - Excess lanes are dropped silently. Exceeding ib_spots is a fetch protocol violation; assert in sim.
- Dequeue:
  - taken = min(num_dispatched, inst_buffer_instructions_valid).
  - head advances by taken, mod DEPTH.
  - Entries leave in strict program order; dispatch may take only a prefix.
- count_next = count + accepted - taken; the arithmetic never under- or overflows by construction.
- Latency: an enqueued packet is visible on ib_packets the cycle after its edge (1 cycle).
- ib_packets lane k = storage[(head + k) mod DEPTH] for k < valid; lanes at or above valid output 0.
- Wrap-around: pointer sums use an explicit compare-and-subtract against DEPTH, not bit truncation.
- flush:
  - next head = tail = count = 0.
  - Same-cycle fetch_valid and num_dispatched are ignored.
  - Flush has priority over everything except reset.
- Full (count == DEPTH): ib_spots = 0; dequeue is still allowed.
- Empty (count == 0): valid = 0, so num_dispatched is ignored.
- Simultaneous enqueue and dequeue at full or empty: handled by the rules above, no special case.

Optional Feature:
IB_BYPASS_EN
- Defined, when count == 0 and flush == 0:
  - ib_packets = fetch_packets, and inst_buffer_instructions_valid = fetch_valid (clamped to N).
  - Lanes dispatched this cycle are not written.
  - Remaining lanes (fetch_valid - taken) are enqueued at tail.
  - Saves one cycle of fetch-to-dispatch latency.
- Not defined: 1-cycle latency always; outputs are a pure function of registered state.

Decomposition:
- Shared sys_defs package:
  - FETCH_PACKET {inst, PC, NPC, bp_packet, valid}.
  - `N, `IB_SZ (DEPTH), `NUM_SCALAR_BITS, IB_IDX typedef.
- No sub-module is natural. The modular pointer add is a local function; storage is a flat register array.

Test Plan (N=3, DEPTH=8):
- Reset then fetch_valid=3 packets PC 0x0,0x4,0x8, num_dispatched=0 -> next cycle valid=3, lanes hold PCs in order, ib_count=3, ib_spots=3.
- Fill to 8 over three cycles (3,3,2), no dispatch -> ib_spots=0; a further fetch_valid=3 leaves count at 8 and storage unchanged.
- count=5, fetch_valid=3, num_dispatched=2 -> count_next=6, head advances 2, the new packets are appended after the old ones.
- head=6, count=2, enqueue 3 -> entries land at indices 0,1,2 (wrap); dispatch 3 per cycle returns PCs in program order.
- count=6 with flush=1, fetch_valid=3, num_dispatched=3 in the same cycle -> next cycle count=0, valid=0, ib_spots=3.
- Assert reset mid-stream with count=4, asynchronously between edges -> outputs immediately show valid=0, ib_spots=3; with IB_BYPASS_EN, empty buffer plus fetch_valid=2 gives same-cycle valid=2.

Source files
------------

// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the instruction buffer: fetch packet layout, default
// machine width and buffer depth, and the derived index/count types.
// Optional feature macro used by inst_buffer: IB_BYPASS_EN.

package inst_buffer_pkg;

    // Default superscalar width and buffer depth for the core.
    localparam int unsigned IB_N            = 3;
    localparam int unsigned IB_SZ           = 16;
    localparam int unsigned NUM_SCALAR_BITS = $clog2(IB_N + 1);

    typedef logic [$clog2(IB_SZ)-1:0] ib_idx_t;

    // Branch-predictor state carried alongside each fetched instruction.
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } bp_packet_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        bp_packet_t  bp_packet;
        logic        valid;
    } fetch_packet_t;

endpackage

// File: rtl/inst_buffer.sv
// N-wide circular instruction buffer between fetch/decode and dispatch.
// Accepts up to N packets per cycle, presents the oldest up to N to dispatch,
// retires the prefix dispatch reports as taken, and empties on flush.
// Optional feature: define IB_BYPASS_EN to forward fetch packets straight to
// dispatch when the buffer is empty, saving one cycle of latency.

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned N        = IB_N,
    parameter int unsigned DEPTH    = IB_SZ,
    parameter int unsigned CNT_BITS = $clog2(N + 1),
    parameter int unsigned PTR_BITS = $clog2(DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  fetch_packet_t [N-1:0]         fetch_packets,
    input  logic [CNT_BITS-1:0]           fetch_valid,
    output logic [CNT_BITS-1:0]           ib_spots,
    output fetch_packet_t [N-1:0]         ib_packets,
    output logic [CNT_BITS-1:0]           inst_buffer_instructions_valid,
    input  logic [CNT_BITS-1:0]           num_dispatched,
    input  logic                          flush,
    output logic [$clog2(DEPTH+1)-1:0]    ib_count
);

    localparam int unsigned COUNT_BITS = $clog2(DEPTH + 1);
    localparam int unsigned LANE_W     = (N > 1) ? $clog2(N) : 1;

    typedef logic [PTR_BITS-1:0]   ptr_t;
    typedef logic [COUNT_BITS-1:0] cnt_t;

    // Modular pointer add; DEPTH need not be a power of two, so wrap with an
    // explicit compare-and-subtract instead of relying on bit truncation.
    function automatic ptr_t ptr_add(input ptr_t ptr, input int unsigned inc);
        int unsigned sum;
        sum = 32'(ptr) + inc;
        if (sum >= DEPTH) begin
            sum = sum - DEPTH;
        end
        return ptr_t'(sum);
    endfunction

    ptr_t          head_q, head_d;
    ptr_t          tail_q, tail_d;
    cnt_t          count_q, count_d;
    fetch_packet_t storage_q [DEPTH];

    logic          bypass;
    int unsigned   spots_u;
    int unsigned   buf_valid_u;
    int unsigned   out_valid_u;
    int unsigned   fetch_u;
    int unsigned   dispatch_u;
    int unsigned   taken_u;
    int unsigned   enq_u;
    int unsigned   deq_u;
    int unsigned   skip_u;

    fetch_packet_t [N-1:0] enq_data;

    // Occupancy-derived limits and the enqueue/dequeue amounts for this cycle.
    always_comb begin
        int unsigned free_u;
        free_u      = DEPTH - 32'(count_q);
        spots_u     = (free_u < N) ? free_u : N;
        buf_valid_u = (32'(count_q) < N) ? 32'(count_q) : N;

        fetch_u     = 32'(fetch_valid);
        if (fetch_u > N) begin
            fetch_u = N;
        end
        dispatch_u  = 32'(num_dispatched);

`ifdef IB_BYPASS_EN
        bypass = (count_q == '0) && !flush;
`else
        bypass = 1'b0;
`endif

        out_valid_u = 0;
        taken_u     = 0;
        enq_u       = 0;
        deq_u       = 0;
        skip_u      = 0;

        if (bypass) begin
            // Dispatch sees fetch directly; whatever it leaves behind is queued.
            out_valid_u = fetch_u;
            taken_u     = (dispatch_u < fetch_u) ? dispatch_u : fetch_u;
            enq_u       = fetch_u - taken_u;
            skip_u      = taken_u;
            deq_u       = 0;
        end else begin
            // Spots come from the pre-dequeue count: freed space is not reused.
            out_valid_u = buf_valid_u;
            taken_u     = (dispatch_u < buf_valid_u) ? dispatch_u : buf_valid_u;
            enq_u       = (fetch_u < spots_u) ? fetch_u : spots_u;
            deq_u       = taken_u;
            skip_u      = 0;
        end
    end

    // Lanes to be written, shifted down past any lanes consumed via bypass.
    always_comb begin
        for (int unsigned j = 0; j < N; j++) begin
            enq_data[j] = '0;
            if (j + skip_u < N) begin
                enq_data[j] = fetch_packets[LANE_W'(j + skip_u)];
            end
        end
    end

    // Dispatch-facing outputs: oldest entries first, lanes past valid zeroed.
    always_comb begin
        ib_spots                       = CNT_BITS'(spots_u);
        inst_buffer_instructions_valid = CNT_BITS'(out_valid_u);
        ib_count                       = count_q;
        for (int k = 0; k < N; k++) begin
            ib_packets[k] = '0;
            if (32'(k) < out_valid_u) begin
                if (bypass) begin
                    ib_packets[k] = fetch_packets[k];
                end else begin
                    ib_packets[k] = storage_q[ptr_add(head_q, 32'(k))];
                end
            end
        end
    end

    // Pointer and occupancy next state; flush wins over fetch and dispatch.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = ptr_add(head_q, deq_u);
            tail_d  = ptr_add(tail_q, enq_u);
            count_d = cnt_t'(32'(count_q) + enq_u - deq_u);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset so it is not cleared.
    always_ff @(posedge clock) begin
        if (!flush) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (j < enq_u) begin
                    storage_q[ptr_add(tail_q, j)] <= enq_data[j];
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Fetch must never offer more lanes than the buffer advertised.
    fetch_within_spots: assert property (
        @(posedge clock) disable iff (reset || flush)
        32'(fetch_valid) <= 32'(ib_spots)
    ) else $error("inst_buffer: fetch_valid %0d exceeds ib_spots %0d",
                  fetch_valid, ib_spots);
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer (N=3, DEPTH=8, bypass disabled).
// A queue of packets models the buffer in program order.

module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int N          = 3;
    localparam int DEPTH      = 8;
    localparam int CNT_BITS   = 2;
    localparam int COUNT_BITS = 4;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    fetch_packet_t [N-1:0]   fetch_packets;
    logic [CNT_BITS-1:0]     fetch_valid;
    logic [CNT_BITS-1:0]     ib_spots;
    fetch_packet_t [N-1:0]   ib_packets;
    logic [CNT_BITS-1:0]     inst_buffer_instructions_valid;
    logic [CNT_BITS-1:0]     num_dispatched;
    logic                    flush;
    logic [COUNT_BITS-1:0]   ib_count;

    inst_buffer #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clock                          (clock),
        .reset                          (reset),
        .fetch_packets                  (fetch_packets),
        .fetch_valid                    (fetch_valid),
        .ib_spots                       (ib_spots),
        .ib_packets                     (ib_packets),
        .inst_buffer_instructions_valid (inst_buffer_instructions_valid),
        .num_dispatched                 (num_dispatched),
        .flush                          (flush),
        .ib_count                       (ib_count)
    );

    always #5 clock = ~clock;

    fetch_packet_t model_q [$];
    int            checks = 0;
    int            errors = 0;
    logic [31:0]   pc_next = 32'h0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int model_valid();
        return imin(N, model_q.size());
    endfunction

    function automatic int model_spots();
        return imin(N, DEPTH - model_q.size());
    endfunction

    function automatic fetch_packet_t exp_lane(input int k);
        fetch_packet_t z;
        z = '0;
        if (k < model_valid()) return model_q[k];
        return z;
    endfunction

    // Called at a negedge: applies one cycle of stimulus, advances the model
    // across the rising edge, and returns at the next negedge with inputs idle.
    task automatic drive_cycle(input int fv, input int nd, input bit fl);
        fetch_packet_t p;
        int taken;
        int acc;
        for (int k = 0; k < N; k++) begin
            p.inst             = $urandom;
            p.pc               = pc_next + 32'(4 * k);
            p.npc              = p.pc + 32'd4;
            p.bp_packet.taken  = 1'($urandom);
            p.bp_packet.target = $urandom;
            p.valid            = (k < fv);
            fetch_packets[k]   = p;
        end
        fetch_valid    = CNT_BITS'(fv);
        num_dispatched = CNT_BITS'(nd);
        flush          = fl;
        if (fl) begin
            model_q.delete();
        end else begin
            taken = imin(nd, model_valid());
            acc   = imin(fv, model_spots());
            for (int i = 0; i < taken; i++) void'(model_q.pop_front());
            for (int k = 0; k < acc; k++) model_q.push_back(fetch_packets[k]);
            pc_next = pc_next + 32'(4 * acc);
        end
        @(posedge clock);
        @(negedge clock);
        fetch_valid    = '0;
        num_dispatched = '0;
        flush          = 1'b0;
    endtask

    task automatic test_reset();
        fetch_valid    = '0;
        num_dispatched = '0;
        flush          = 1'b0;
        fetch_packets  = '0;
        #1 reset = 1'b1;
        #2;
        checks++;
        if (ib_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", ib_count);
        end
        checks++;
        if (inst_buffer_instructions_valid !== 2'd0) begin
            errors++;
            $display("FAIL reset_valid: got %0d want 0", inst_buffer_instructions_valid);
        end
        checks++;
        if (ib_spots !== 2'd3) begin
            errors++;
            $display("FAIL reset_spots: got %0d want 3", ib_spots);
        end
        checks++;
        if (ib_packets !== '0) begin
            errors++;
            $display("FAIL reset_packets: got %h want 0", ib_packets);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        drive_cycle(3, 0, 0);
        checks++;
        if (inst_buffer_instructions_valid !== 2'd3 || ib_count !== 4'd3 || ib_spots !== 2'd3) begin
            errors++;
            $display("FAIL basic_counts: got valid=%0d count=%0d spots=%0d want 3/3/3",
                     inst_buffer_instructions_valid, ib_count, ib_spots);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ib_packets[k].pc !== 32'(4 * k) || ib_packets[k] !== exp_lane(k)) begin
                errors++;
                $display("FAIL basic_lane%0d: got pc=%h want pc=%h", k, ib_packets[k].pc, 4 * k);
            end
        end
    endtask

    task automatic test_fill_full();
        drive_cycle(3, 0, 0);
        drive_cycle(2, 0, 0);
        checks++;
        if (ib_count !== 4'd8 || ib_spots !== 2'd0 || inst_buffer_instructions_valid !== 2'd3) begin
            errors++;
            $display("FAIL full_counts: got count=%0d spots=%0d valid=%0d want 8/0/3",
                     ib_count, ib_spots, inst_buffer_instructions_valid);
        end
        drive_cycle(0, 0, 0);
        checks++;
        if (ib_count !== 4'd8 || ib_packets[0].pc !== 32'h0 || ib_packets[2].pc !== 32'h8) begin
            errors++;
            $display("FAIL full_hold: got count=%0d pc0=%h pc2=%h want 8/0/8",
                     ib_count, ib_packets[0].pc, ib_packets[2].pc);
        end
        // Dequeue is still allowed while full.
        drive_cycle(0, 3, 0);
        checks++;
        if (ib_count !== 4'd5 || ib_spots !== 2'd3 || ib_packets[0].pc !== 32'hc) begin
            errors++;
            $display("FAIL full_dispatch: got count=%0d spots=%0d pc0=%h want 5/3/c",
                     ib_count, ib_spots, ib_packets[0].pc);
        end
    endtask

    task automatic test_enq_deq();
        drive_cycle(3, 2, 0);
        checks++;
        if (ib_count !== 4'd6) begin
            errors++;
            $display("FAIL enqdeq_count: got %0d want 6", ib_count);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ib_packets[k].pc !== 32'(20 + 4 * k) || ib_packets[k] !== exp_lane(k)) begin
                errors++;
                $display("FAIL enqdeq_lane%0d: got pc=%h want pc=%h", k, ib_packets[k].pc, 20 + 4 * k);
            end
        end
        drive_cycle(0, 3, 0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (ib_packets[k].pc !== 32'(32 + 4 * k) || ib_packets[k] !== exp_lane(k)) begin
                errors++;
                $display("FAIL enqdeq_appended%0d: got pc=%h want pc=%h", k, ib_packets[k].pc, 32 + 4 * k);
            end
        end
    endtask

    task automatic test_flush();
        drive_cycle(3, 0, 0);
        checks++;
        if (ib_count !== 4'd6) begin
            errors++;
            $display("FAIL flush_pre_count: got %0d want 6", ib_count);
        end
        drive_cycle(3, 3, 1);
        checks++;
        if (ib_count !== 4'd0 || inst_buffer_instructions_valid !== 2'd0 || ib_spots !== 2'd3) begin
            errors++;
            $display("FAIL flush_state: got count=%0d valid=%0d spots=%0d want 0/0/3",
                     ib_count, inst_buffer_instructions_valid, ib_spots);
        end
        checks++;
        if (ib_packets !== '0) begin
            errors++;
            $display("FAIL flush_packets: got %h want 0", ib_packets);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] base;
        base = pc_next;
        drive_cycle(3, 0, 0);
        drive_cycle(3, 0, 0);
        drive_cycle(2, 0, 0);
        drive_cycle(0, 3, 0);
        drive_cycle(0, 3, 0);
        checks++;
        if (ib_count !== 4'd2) begin
            errors++;
            $display("FAIL wrap_pre_count: got %0d want 2", ib_count);
        end
        // head sits at 6 with two entries; these three land at indices 0..2.
        drive_cycle(3, 0, 0);
        checks++;
        if (ib_count !== 4'd5) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 5", ib_count);
        end
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < model_valid(); k++) begin
                checks++;
                if (ib_packets[k].pc !== base + 32'(24 + 4 * (3 * c + k)) ||
                    ib_packets[k] !== exp_lane(k)) begin
                    errors++;
                    $display("FAIL wrap_order_c%0d_l%0d: got pc=%h want pc=%h", c, k,
                             ib_packets[k].pc, base + 32'(24 + 4 * (3 * c + k)));
                end
            end
            drive_cycle(0, 3, 0);
        end
        checks++;
        if (ib_count !== 4'd0 || inst_buffer_instructions_valid !== 2'd0) begin
            errors++;
            $display("FAIL wrap_drain: got count=%0d valid=%0d want 0/0",
                     ib_count, inst_buffer_instructions_valid);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(3, 0, 0);
        drive_cycle(1, 0, 0);
        checks++;
        if (ib_count !== 4'd4) begin
            errors++;
            $display("FAIL areset_pre_count: got %0d want 4", ib_count);
        end
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        model_q.delete();
        checks++;
        if (inst_buffer_instructions_valid !== 2'd0 || ib_spots !== 2'd3 || ib_count !== 4'd0) begin
            errors++;
            $display("FAIL areset_immediate: got valid=%0d spots=%0d count=%0d want 0/3/0",
                     inst_buffer_instructions_valid, ib_spots, ib_count);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_random();
        int fv;
        int nd;
        bit fl;
        for (int i = 0; i < 300; i++) begin
            fv = $urandom_range(0, model_spots());
            nd = $urandom_range(0, N);
            fl = ($urandom_range(0, 24) == 0);
            drive_cycle(fv, nd, fl);
            checks++;
            if (ib_count !== 4'(model_q.size()) ||
                inst_buffer_instructions_valid !== 2'(model_valid()) ||
                ib_spots !== 2'(model_spots())) begin
                errors++;
                $display("FAIL rand_counts_%0d: got count=%0d valid=%0d spots=%0d want %0d/%0d/%0d",
                         i, ib_count, inst_buffer_instructions_valid, ib_spots,
                         model_q.size(), model_valid(), model_spots());
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (ib_packets[k] !== exp_lane(k)) begin
                    errors++;
                    $display("FAIL rand_lane_%0d_%0d: got pc=%h want pc=%h", i, k,
                             ib_packets[k].pc, exp_lane(k).pc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_full();
        test_enq_deq();
        test_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
